// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu_add floating-point adder
// (1 sign, 6 exponent bits at bias 31, 25 stored fraction bits).
package fpu_pkg;

    localparam int EXP_W  = 6;
    localparam int FRAC_W = 25;
    localparam int BIAS   = 31;
    localparam int MANT_W = FRAC_W + 1;   // with hidden one
    localparam int EXT_W  = MANT_W + 3;   // plus guard, round, sticky
    localparam int LZ_W   = 5;

    localparam logic [EXP_W-1:0] EXP_MAX = 6'h3F;

    localparam int ST_EXACT   = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_UNF     = 2;
    localparam int ST_INEXACT = 3;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4
    } state_t;

endpackage

// File: rtl/fpu_add_lzc.sv
// Combinational leading-zero counter over the extended significand,
// used to renormalise after a cancelling subtraction.
module fpu_lzc
    import fpu_pkg::*;
(
    input  logic [EXT_W-1:0] value,
    output logic [LZ_W-1:0]  count
);

    logic found_s;

    // Priority scan from the MSB down; all-zero input reports EXT_W
    always_comb begin
        count   = LZ_W'(EXT_W);
        found_s = 1'b0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (!found_s && value[i]) begin
                count   = LZ_W'(EXT_W - 1 - i);
                found_s = 1'b1;
            end else begin
                count   = count;
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fpu_add.sv
// Free-running five-state floating-point adder: LOAD, ALIGN, ADD, NORM,
// ROUND; one registered result with one-hot status every five cycles.
module fpu_add
    import fpu_pkg::*;
(
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic [31:0] Op_A_in,
    input  logic [31:0] Op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam int SH_W = MANT_W + EXT_W - 1;

    state_t             state_r;
    logic               sa_r, sb_r, za_r, zb_r;
    logic [EXP_W-1:0]   ea_r, eb_r;
    logic [MANT_W-1:0]  ma_r, mb_r;
    logic               ovf_in_r, byp_r, sign_r, sub_r, zero_r;
    logic [31:0]        byp_val_r;
    logic signed [8:0]  exp_r;
    logic [EXT_W-1:0]   big_ext_r, small_ext_r, norm_r;
    logic [EXT_W:0]     sum_r;

    fp_t                in_a_s, in_b_s;
    logic               swap_s, big_sign_s;
    logic [EXP_W-1:0]   big_e_s, small_e_s, diff_s, diff_c_s;
    logic [MANT_W-1:0]  big_m_s, small_m_s;
    logic [SH_W-1:0]    shift_s;
    logic [EXT_W-1:0]   small_ext_s, norm_s;
    logic [31:0]        byp_val_s;
    logic [EXT_W:0]     sum_s;
    logic [LZ_W-1:0]    lz_s;
    logic signed [8:0]  norm_exp_s, exp_f_s;
    logic               round_up_s, inexact_s;
    logic [MANT_W:0]    rnd_s;
    logic [FRAC_W-1:0]  frac_s;
    logic [31:0]        data_s;
    logic [3:0]         status_s;

    assign in_a_s = Op_A_in;
    assign in_b_s = Op_B_in;

    fpu_lzc u_lzc (
        .value (sum_r[EXT_W-1:0]),
        .count (lz_s)
    );

    // Order operands by magnitude and right-align the smaller one
    always_comb begin
        swap_s = (ea_r < eb_r) || ((ea_r == eb_r) && (ma_r < mb_r));
        if (swap_s) begin
            big_sign_s = sb_r;  big_e_s = eb_r;  small_e_s = ea_r;
            big_m_s    = mb_r;  small_m_s = ma_r;
        end else begin
            big_sign_s = sa_r;  big_e_s = ea_r;  small_e_s = eb_r;
            big_m_s    = ma_r;  small_m_s = mb_r;
        end
        diff_s = big_e_s - small_e_s;
        // Any shift of 28 or more leaves only sticky, so clamp it there
        diff_c_s    = (diff_s > 6'd28) ? 6'd28 : diff_s;
        shift_s     = {small_m_s, 28'd0} >> diff_c_s;
        small_ext_s = {shift_s[SH_W-1:SH_W-28], |shift_s[SH_W-29:0]};
    end

    // Zero operands pass the other operand through untouched
    always_comb begin
        if (za_r && zb_r) begin
            byp_val_s = 32'h0000_0000;
        end else if (za_r) begin
            byp_val_s = {sb_r, eb_r, mb_r[FRAC_W-1:0]};
        end else begin
            byp_val_s = {sa_r, ea_r, ma_r[FRAC_W-1:0]};
        end
    end

    // Magnitude add or subtract; big_ext_r never falls below small_ext_r
    always_comb begin
        if (sub_r) begin
            sum_s = {1'b0, big_ext_r} - {1'b0, small_ext_r};
        end else begin
            sum_s = {1'b0, big_ext_r} + {1'b0, small_ext_r};
        end
    end

    // Normalise: carry shifts right into sticky, otherwise shift out leading zeros
    always_comb begin
        if (sum_r[EXT_W]) begin
            norm_s     = {sum_r[EXT_W:2], sum_r[1] | sum_r[0]};
            norm_exp_s = exp_r + 9'sd1;
        end else begin
            norm_s     = sum_r[EXT_W-1:0] << lz_s;
            norm_exp_s = exp_r - $signed({4'd0, lz_s});
        end
    end

    // Round to nearest even, then classify with overflow first
    always_comb begin
        inexact_s  = |norm_r[2:0];
        round_up_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
        rnd_s      = {1'b0, norm_r[EXT_W-1:3]} + {{MANT_W{1'b0}}, round_up_s};
        if (rnd_s[MANT_W]) begin
            frac_s  = rnd_s[FRAC_W:1];
            exp_f_s = exp_r + 9'sd1;
        end else begin
            frac_s  = rnd_s[FRAC_W-1:0];
            exp_f_s = exp_r;
        end
        data_s   = 32'h0000_0000;
        status_s = 4'b0000;
        if (ovf_in_r) begin
            data_s = {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
            status_s[ST_OVF] = 1'b1;
        end else if (byp_r) begin
            data_s = byp_val_r;
            status_s[ST_EXACT] = 1'b1;
        end else if (zero_r) begin
            status_s[ST_EXACT] = 1'b1;
        end else if (exp_f_s >= 9'sd63) begin
            data_s = {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
            status_s[ST_OVF] = 1'b1;
        end else if (exp_f_s < 9'sd1) begin
            status_s[ST_UNF] = 1'b1;
        end else if (inexact_s) begin
            data_s = {sign_r, exp_f_s[EXP_W-1:0], frac_s};
            status_s[ST_INEXACT] = 1'b1;
        end else begin
            data_s = {sign_r, exp_f_s[EXP_W-1:0], frac_s};
            status_s[ST_EXACT] = 1'b1;
        end
    end

    // Sequencer and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            state_r     <= LOAD;
            sa_r        <= 1'b0;   sb_r <= 1'b0;
            za_r        <= 1'b0;   zb_r <= 1'b0;
            ea_r        <= '0;     eb_r <= '0;
            ma_r        <= '0;     mb_r <= '0;
            ovf_in_r    <= 1'b0;   byp_r <= 1'b0;
            byp_val_r   <= 32'h0000_0000;
            sign_r      <= 1'b0;   sub_r <= 1'b0;
            zero_r      <= 1'b0;
            exp_r       <= 9'sd0;
            big_ext_r   <= '0;     small_ext_r <= '0;
            sum_r       <= '0;     norm_r <= '0;
            data_out    <= 32'h0000_0000;
            status_out  <= 4'b0000;
        end else begin
            case (state_r)
                LOAD: begin
                    sa_r     <= in_a_s.sign;
                    sb_r     <= in_b_s.sign;
                    ea_r     <= in_a_s.exp;
                    eb_r     <= in_b_s.exp;
                    ma_r     <= {1'b1, in_a_s.frac};
                    mb_r     <= {1'b1, in_b_s.frac};
                    za_r     <= (in_a_s.exp == 6'd0);
                    zb_r     <= (in_b_s.exp == 6'd0);
                    ovf_in_r <= (in_a_s.exp == EXP_MAX) || (in_b_s.exp == EXP_MAX);
                    state_r  <= ALIGN;
                end
                ALIGN: begin
                    sign_r      <= big_sign_s;
                    sub_r       <= sa_r ^ sb_r;
                    exp_r       <= $signed({3'd0, big_e_s});
                    big_ext_r   <= {big_m_s, 3'b000};
                    small_ext_r <= small_ext_s;
                    byp_r       <= za_r | zb_r;
                    byp_val_r   <= byp_val_s;
                    state_r     <= ADD;
                end
                ADD: begin
                    sum_r   <= sum_s;
                    zero_r  <= (sum_s == '0);
                    sign_r  <= (sum_s == '0) ? 1'b0 : sign_r;
                    state_r <= NORM;
                end
                NORM: begin
                    norm_r  <= norm_s;
                    exp_r   <= norm_exp_s;
                    state_r <= ROUND;
                end
                ROUND: begin
                    data_out   <= data_s;
                    status_out <= status_s;
                    state_r    <= LOAD;
                end
                default: begin
                    state_r <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add.sv
// Directed bench for fpu_add: hand-computed sums, exceptions, rounding,
// operand-hold behaviour and reset abort.
module tb_fpu_add;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a, op_b;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] prev_d;

    fpu_add dut (
        .clock_100Khz (clk),
        .reset        (reset),
        .Op_A_in      (op_a),
        .Op_B_in      (op_b),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered just before a LOAD edge; scrambles inputs after LOAD to show they are ignored
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic [3:0] exp_s);
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        op_a = $urandom();
        op_b = $urandom();
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, data_out, prev_d);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_stat"}, {28'd0, status_out}, {28'd0, exp_s});
        prev_d = exp_d;
    endtask

    initial begin
        reset  = 1'b1;
        op_a   = 32'h0000_0000;
        op_b   = 32'h0000_0000;
        prev_d = 32'h0000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_out, 32'h0000_0000);
        check("rst_stat", {28'd0, status_out}, 32'h0000_0000);
        reset = 1'b0;

        run("one_plus_two",  32'h3E00_0000, 32'h4000_0000, 32'h4100_0000, 4'b0001);
        run("three_minus3",  32'h4100_0000, 32'hC100_0000, 32'h0000_0000, 4'b0001);
        run("max_plus_max",  32'h7DFF_FFFF, 32'h7DFF_FFFF, 32'h7E00_0000, 4'b0010);
        run("underflow",     32'h0200_0001, 32'h8200_0000, 32'h0000_0000, 4'b0100);
        run("tie_even",      32'h3E00_0000, 32'h0A00_0000, 32'h3E00_0000, 4'b1000);
        run("above_half",    32'h3E00_0000, 32'h0A00_0001, 32'h3E00_0001, 4'b1000);
        run("round_carry",   32'h3FFF_FFFF, 32'h0A00_0000, 32'h4000_0000, 4'b1000);
        run("two_minus_one", 32'h4000_0000, 32'hBE00_0000, 32'h3E00_0000, 4'b0001);
        run("zero_a",        32'h0000_0000, 32'hC100_0000, 32'hC100_0000, 4'b0001);
        run("both_neg_zero", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0001);
        run("inf_input",     32'h7E00_0000, 32'h3E00_0000, 32'h7E00_0000, 4'b0010);
        run("one_plus_two2", 32'h3E00_0000, 32'h4000_0000, 32'h4100_0000, 4'b0001);

        // Abort during ADD: outputs clear on the next edge
        op_a = 32'h3E00_0000;
        op_b = 32'h4000_0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_data", data_out, 32'h0000_0000);
        check("abort_stat", {28'd0, status_out}, 32'h0000_0000);
        reset  = 1'b0;
        prev_d = 32'h0000_0000;
        run("after_abort",   32'h3E00_0000, 32'h4000_0000, 32'h4100_0000, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_add.md
Name: fpu_add

Overview:
- Sequential floating-point adder for a custom 32-bit format: sign[31], exponent[30:25] (6 bits, bias 31), fraction[24:0] (25 bits, hidden leading 1).
- Runs continuously from a single clock: it samples two operands, computes A+B through a fixed 5-state FSM, and registers the result with a 4-bit one-hot status.
- Sits as the arithmetic core behind the system's register or bus front end.

Parameters:
- EXP_W, 6, exponent width.
- FRAC_W, 25, stored fraction width.
- BIAS, 31, exponent bias.

Ports:
- clock_100Khz  input  1  system clock. Single clock domain, nominal 100 kHz.
- reset  input  1  synchronous, active-high reset.
- Op_A_in  input  32  operand A.
- Op_B_in  input  32  operand B.
- data_out  output  32  result register.
- status_out  output  4  one-hot status register: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT.

Behaviour:
- Clocking and reset: one clock, clock_100Khz. Reset is synchronous and active-high; all state changes happen on the rising edge.
- While reset=1:
  - state=LOAD.
  - data_out=0 and status_out=0.
  - Internal registers are cleared.
  - Asserting reset mid-operation aborts the computation with no partial result written.
- FSM sequence: LOAD -> ALIGN -> ADD -> NORM -> ROUND -> LOAD, free-running. There is no handshake.
- Per state:
  - LOAD: capture Op_A_in and Op_B_in. Unpack them, prepend the hidden 1, and flag zero operands (exponent 0 means the operand is zero; denormals are flushed).
  - ALIGN: swap operands so that A has the larger magnitude. Right-shift B's significand by the exponent difference. Extend with guard, round and sticky bits; sticky is the OR of all bits shifted past the round bit.
  - ADD: if signs are equal, add significands; otherwise subtract B from A. Result sign = sign of the larger magnitude. An exact zero difference yields +0.
  - NORM: on carry-out, shift right 1 and increment the exponent (the shifted-out bit joins sticky). Otherwise, left-shift by the leading-zero count and decrement the exponent by the same amount. Use a single-cycle priority encoder.
  - ROUND: round to nearest, ties to even. A mantissa carry from rounding renormalises and increments the exponent. Register data_out and status_out.
- Latency: operands sampled at the LOAD edge appear on data_out/status_out 4 edges later. A new result is produced every 5 cycles. Outputs hold between updates.
- Exceptions and status (exactly one bit set after the first result):
  - Overflow: final exponent >=63, or either input has exponent 63. data_out={sign,6'h3F,25'h0}; status=0010.
  - Underflow: final biased exponent <1 for a nonzero true result. data_out=32'h0; status=0100.
  - Inexact: any nonzero guard, round or sticky bit before rounding. status=1000.
  - Exact: otherwise, including a zero result. status=0001.
  - Priority: OVERFLOW > UNDERFLOW > INEXACT > EXACT.
- Special cases:
  - Zero operand: the result is the other operand exactly; status EXACT.
  - Both operands zero: result +0.
  - Operand changes outside the LOAD state are ignored.

Decomposition:
- Shared package fpu_pkg holds:
  - EXP_W, FRAC_W, BIAS.
  - A packed struct for {sign, exp, frac}.
  - The state enum {LOAD, ALIGN, ADD, NORM, ROUND}.
  - Status bit index constants ST_EXACT=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3.
- One sub-module: fpu_lzc, a combinational leading-zero counter used in NORM.

Test Plan:
- Reset=1 for 2 cycles -> data_out=0, status_out=0. Release, then A=32'h3E000000 (1.0), B=32'h40000000 (2.0) -> after 4 edges data_out=32'h41000000 (3.0), status_out=4'b0001.
- A=32'h41000000 (3.0), B=32'hC1000000 (-3.0) -> data_out=32'h00000000, status=0001.
- A=B=32'h7DFFFFFF (maximum finite) -> data_out=32'h7E000000, status=0010.
- A=32'h02000001, B=32'h82000000 (result 2^-55) -> data_out=32'h00000000, status=0100.
- A=32'h3E000000 (1.0), B=32'h0A000000 (2^-26, an exact tie) -> rounds to even: data_out=32'h3E000000, status=1000.
- Start 1.0+2.0, assert reset during the ADD state -> outputs go to 0 at the next edge; after release the FSM restarts in LOAD and produces the correct result.
